// File: rtl/carry_chain_rr_arbiter.sv
// ============================================================================
// carry_chain_rr_arbiter
//   Registered round-robin arbiter with an optional hold-timeout (ARB_TIMEOUT_EN)
//   Revision: 1.0
// ============================================================================
`default_nettype none

module carry_chain_rr_arbiter #(
   parameter int N_REQ    = 12,
   parameter int MAX_HOLD = 16,
   parameter int IDX_W    = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req,
   output logic             timeout_pulse
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDX_W-1:0]       last_idx;
   logic [2*N_REQ-1:0]     req_dbl;
   logic [IDX_W:0]         rot_amt;
   logic [N_REQ-1:0]       req_rot;
   int                     win_off;
   int                     win_pos;
   logic [IDX_W-1:0]       win_idx;
   logic                   any_now;
   logic                   owner_req;
   logic                   timeout_ok;
   logic                   load;
   logic                   go_idle;
   logic                   timeout_now;

   assign any_now   = |req;
   assign owner_req = req[last_idx];

   // Rotate so bit 0 is the requester just after the last owner; the owner lands on the top bit.
   assign req_dbl = {req, req};
   assign rot_amt = {1'b0, last_idx} + (IDX_W+1)'(1);
   assign req_rot = N_REQ'(req_dbl >> rot_amt);

   always_comb begin
      win_off = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_off = k;
         end
      end
      win_pos = int'(last_idx) + 1 + win_off;
      if (win_pos >= N_REQ) begin
         win_pos = win_pos - N_REQ;
      end
      win_idx = IDX_W'(win_pos);
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   logic [HOLD_W-1:0] hold_cnt;

   assign timeout_ok = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && (|(req & ~grant));

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (load || (state_nxt == IDLE)) begin
         hold_cnt <= '0;
      end else if ((state == OWN) && (hold_cnt != HOLD_W'(MAX_HOLD - 1))) begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end
   end
`else
   assign timeout_ok = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      go_idle     = 1'b0;
      timeout_now = 1'b0;
      case (state)
         IDLE: begin
            if (any_now) begin
               load      = 1'b1;
               state_nxt = OWN;
            end
         end
         OWN: begin
            // A release wins over a coincident timeout, so the pulse stays low then.
            if (!owner_req) begin
               if (any_now) begin
                  load = 1'b1;
               end else begin
                  go_idle   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (timeout_ok) begin
               load        = 1'b1;
               timeout_now = 1'b1;
            end
         end
         default: begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last_idx      <= IDX_W'(N_REQ - 1);
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_idx     <= '0;
         any_req       <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         any_req       <= any_now;
         timeout_pulse <= timeout_now;
         if (load) begin
            grant       <= N_REQ'(1) << win_idx;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            last_idx    <= win_idx;
         end else if (go_idle) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_carry_chain_rr_arbiter.sv
// ============================================================================
// tb_carry_chain_rr_arbiter
//   Directed bench for carry_chain_rr_arbiter (N_REQ=12, MAX_HOLD=16)
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_carry_chain_rr_arbiter;

   localparam int N_REQ    = 12;
   localparam int MAX_HOLD = 16;
   localparam int IDX_W    = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             any_req;
   logic             timeout_pulse;

   int vectors = 0;
   int errs    = 0;

   carry_chain_rr_arbiter #(
      .N_REQ    (N_REQ),
      .MAX_HOLD (MAX_HOLD),
      .IDX_W    (IDX_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .grant_idx     (grant_idx),
      .any_req       (any_req),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_own(input string tag, input int i);
      chk({tag, ".grant"}, 32'(grant), 32'(1) << i);
      chk({tag, ".valid"}, 32'(grant_valid), 32'd1);
      chk({tag, ".idx"}, 32'(grant_idx), 32'(i));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".grant"}, 32'(grant), 32'd0);
      chk({tag, ".valid"}, 32'(grant_valid), 32'd0);
      chk({tag, ".idx"}, 32'(grant_idx), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      tick(); tick(); tick();
      chk_idle("rst");
      chk("rst.any", 32'(any_req), 32'd0);
      chk("rst.tp", 32'(timeout_pulse), 32'd0);

      reset = 1'b0;
      tick();
      chk_idle("noreq");
      chk("noreq.any", 32'(any_req), 32'd0);

      // single request, one-cycle latency
      req = 12'h010;
      tick();
      chk_own("single", 4);
      chk("single.any0", 32'(any_req), 32'd1);
      tick();
      chk_own("single.hold", 4);
      chk("single.any1", 32'(any_req), 32'd1);
      req = 12'h000;
      tick();
      chk_idle("single.rel");
      tick();
      chk("single.any2", 32'(any_req), 32'd0);

      // fair rotation starting from a fresh reset (search begins at 0)
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req   = 12'hFFF;
      tick();
      chk_own("rot.first", 0);
      for (int i = 0; i < N_REQ; i++) begin
         req = 12'hFFF;
         tick();
         chk_own($sformatf("rot.hold%0d", i), i);
         req = 12'hFFF & ~(12'(1) << i);
         tick();
         chk_own($sformatf("rot.next%0d", i), (i + 1) % N_REQ);
      end

      // wrap-around from last owner 10
      req = 12'h000;
      tick();
      chk_idle("wrap.idle");
      req = 12'h400;
      tick();
      chk_own("wrap.own10", 10);
      req = 12'h803;
      tick();
      chk_own("wrap.own11", 11);
      req = 12'h003;
      tick();
      chk_own("wrap.own0", 0);
      req = 12'h002;
      tick();
      chk_own("wrap.own1", 1);

      // release with and without others pending
      req = 12'h020;
      tick();
      chk_own("rel.own5", 5);
      req = 12'h000;
      tick();
      chk_idle("rel.idle");
      req = 12'h020;
      tick();
      chk_own("rel.again5", 5);

      // hold timeout
      req = 12'h000;
      tick();
      chk_idle("to.idle");
      req = 12'h003;
      tick();
      chk_own("to.start", 0);
      chk("to.tp0", 32'(timeout_pulse), 32'd0);
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
         tick();
      end
      chk_own("to.held16", 0);
      chk("to.tp16", 32'(timeout_pulse), 32'd0);
      tick();
`ifdef ARB_TIMEOUT_EN
      chk_own("to.rotate", 1);
      chk("to.pulse", 32'(timeout_pulse), 32'd1);
      tick();
      chk_own("to.after", 1);
      chk("to.pulse_end", 32'(timeout_pulse), 32'd0);
`else
      chk_own("to.keep", 0);
      chk("to.nopulse", 32'(timeout_pulse), 32'd0);
      for (int i = 0; i < 100; i++) begin
         tick();
      end
      chk_own("to.keep100", 0);
      chk("to.nopulse100", 32'(timeout_pulse), 32'd0);
`endif

      // reset while owner 7 holds
      req = 12'h080;
      tick();
      chk_own("mid.own7", 7);
      reset = 1'b1;
      tick();
      chk_idle("mid.rst");
      chk("mid.any", 32'(any_req), 32'd0);
      chk("mid.tp", 32'(timeout_pulse), 32'd0);
      reset = 1'b0;
      req   = 12'h081;
      tick();
      chk_own("mid.restart0", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/carry_chain_rr_arbiter.md
# carry_chain_rr_arbiter

Round-robin arbiter that shares one downstream resource, such as a wide carry-chain reduction datapath or a shared bus, among up to 12 requesters. The "any request pending" detection is a single wide OR-reduction of the request vector. The block issues a registered one-hot grant plus an encoded index. An optional hold-timeout forces rotation so that one requester cannot starve the others.

## Interface
- `N_REQ`, 12: number of requesters, 2..16.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per owner when timeout is compiled in, ≥2.
- `IDX_W`, 4: width of `grant_idx`, equal to clog2(`N_REQ`).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  `N_REQ`: level request, one bit per requester; held until served.
- `grant`  out  `N_REQ`: registered one-hot grant; all zero when no owner.
- `grant_valid`  out  1: registered; high when `grant` is nonzero.
- `grant_idx`  out  `IDX_W`: registered index of the owner; 0 when `grant_valid` is low.
- `any_req`  out  1: registered OR-reduction of `req`.
- `timeout_pulse`  out  1: one-cycle strobe on forced rotation; constant 0 without the macro.

## Operation
- State machine, 2 states:
  - IDLE: no owner.
  - OWN: `grant` is one-hot.
- Internal `last_idx` register: index of the most recent owner. Reset value `N_REQ`-1, so the first search starts at requester 0.
- Round-robin search: select the first set bit of `req` scanning `last_idx`+1, `last_idx`+2, … modulo `N_REQ`, wrapping from `N_REQ`-1 to 0. The current owner is checked last.
- IDLE → OWN: when any `req` bit is sampled high. Grant goes to the search winner; `last_idx` is set to the winner.
- OWN, owner's `req` still high, no timeout: hold the grant; the hold counter increments.
- OWN, owner's `req` sampled low:
  - Others pending: on the same edge, grant moves to the next search winner (no idle bubble).
  - None pending: go to IDLE; `grant` is 0.
- Requests from non-owners never preempt the owner, except through timeout.
- Hold counter: width clog2(`MAX_HOLD`)+1. Cleared on every new grant or in IDLE. Saturates at `MAX_HOLD`-1.
- Reset in any state, mid-grant included: state IDLE, `grant`=0, `grant_valid`=0, `grant_idx`=0, `any_req`=0, `timeout_pulse`=0, counter 0, `last_idx`=`N_REQ`-1.
- `req` bits at index ≥ `N_REQ` do not exist; `grant_idx` never exceeds `N_REQ`-1.

## Timing
- All outputs are registered.
- Latency from `req` rising to `grant`: 1 cycle. If `req[i]` is high before edge k, `grant[i]` is high after edge k.
- Release-to-handover: owner drops `req` before edge k → new owner, or zero grant, after edge k.
- `any_req` lags `req` by 1 cycle.
- `grant`, `grant_valid` and `grant_idx` always change on the same edge and are mutually consistent.
- Simultaneous owner release and timeout in one cycle: treat as a release; `timeout_pulse` stays 0.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - When the owner has held the grant for `MAX_HOLD` consecutive cycles and another `req` bit is high, the next edge rotates the grant to the search winner.
  - `timeout_pulse` is 1 for that cycle.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- `ARB_TIMEOUT_EN` undefined: there is no forced rotation; the owner holds until it drops `req`. `timeout_pulse` is tied to 0, and the hold counter is not built.

## Test plan
- Reset and single request: hold `reset` 3 cycles, then `req`=12'h000 → all outputs 0. Set `req`=12'h010 → after 1 edge, `grant`=12'h010, `grant_idx`=4, `grant_valid`=1; after the next edge, `any_req`=1.
- Fair rotation: `req`=12'hFFF with each owner dropping its bit for one cycle after 2 grant cycles → grants go 0,1,2,…,11,0 in order, with no idle cycles between owners.
- Wrap-around: `last_idx`=10, `req`=12'h803 → grant 11, then 0, then 1.
- Release with no others: owner 5 drops `req` while `req`=0 otherwise → next edge `grant`=0 and state IDLE. A new `req`=12'h020 → grant 5 again after 1 edge.
- Timeout (with `ARB_TIMEOUT_EN`, `MAX_HOLD`=16): `req`=12'h003 held constant → grant 0 for 16 cycles, then grant 1 with `timeout_pulse`=1 for one cycle. Without the macro, grant 0 persists for 100+ cycles.
- Reset mid-grant: assert `reset` while `grant`=12'h080 → after the edge all outputs are 0. Deassert with `req`=12'h081 → grant 0, because the search restarts from index 0.
